gba_pixel_capture: RTL and testbench
====================================

Name: gba_pixel_capture

Overview:
Upstream feeder for the GBA-to-HDMI converter. It takes the PPU's raw BGR555 pixel stream and its line/frame strobes, and tracks the 240x160 raster position. It converts each pixel to RGB6, either by plain bit expansion or by an LCD colour-correction matrix. Output is an (x, y, data, we) write stream that drives the converter's frame-buffer write port directly. Everything runs in the GBA core clock domain.

Parameters:
H_ACTIVE, 240, visible pixels per line
V_ACTIVE, 160, visible lines per frame
PIPE_LAT, 2, fixed input-to-output latency in cycles (documented constant, not tunable)

Ports:
clk  input  1  GBA core clock
reset  input  1  asynchronous, active-high reset
ppu_frame_start  input  1  one-cycle pulse before line 0's first pixel
ppu_line_start  input  1  one-cycle pulse before each line's first pixel (lines 1..159; ignored on a cycle where ppu_frame_start is also high)
ppu_pixel  input  15  BGR555: [14:10]=B, [9:5]=G, [4:0]=R
ppu_pixel_valid  input  1  ppu_pixel is valid this cycle
color_correct  input  1  0 = bit expansion, 1 = LCD matrix; sampled per pixel at stage 0
pixel_data  output  18  RGB6: [17:12]=R, [11:6]=G, [5:0]=B
pixel_x  output  8  column 0..239
pixel_y  output  8  row 0..159
pixel_we  output  1  write strobe, one cycle per accepted pixel
frame_done  output  1  one-cycle pulse when pixel (239,159) is emitted
sync_err  output  1  sticky flag; cleared only by reset or the next clean frame_start

Behaviour:
Clock, reset and outputs
- One clock, clk. reset is asynchronous and active-high.
- On reset, all outputs are 0, the FSM goes to IDLE, x=y=0, and the pipeline valid bits are cleared.

FSM states: IDLE, LINE, WAIT_LINE.
- IDLE: drops pixels. ppu_frame_start moves to LINE with x=0, y=0.
- LINE: each valid pixel is accepted at (x,y), then x++.
  - When the pixel at x=239 is accepted: if y=159, go to IDLE (frame complete); otherwise go to WAIT_LINE.
- WAIT_LINE: drops pixels. ppu_line_start moves to LINE with x=0, y++.

Boundary cases
- ppu_line_start while in LINE with x<240 (short line): set sync_err, y++, x=0, stay in LINE. If y was already 159, go to IDLE instead and raise no frame_done.
- ppu_frame_start in any state other than IDLE (resync): restart at x=0, y=0 in LINE. Set sync_err unless the FSM was in IDLE.
- A pixel accepted in the same cycle as a strobe belongs to the new position. The strobe takes effect first, and the pixel is accepted as x=0 of the new line.
- Dropped pixels produce no pixel_we and do not set sync_err.
- A frame_start that arrives in IDLE with sync_err set clears it ("clean frame_start").

Pipeline (latency exactly 2 cycles; no backpressure)
- Stage 0, the cycle a pixel is accepted: register r5, g5, b5, x, y, mode and a valid bit.
- Stage 1, mode 0: R6={r5,r5[4]}, and likewise for G and B.
- Stage 1, mode 1, using unsigned 10-bit sums:
  - R6=(26r+4g+2b)>>4
  - G6=(2r+28g+2b)>>4
  - B6=(2r+4g+26b)>>4
  - Maximum is 62, so no saturation is needed. Truncate; do not round.
- The registered outputs become valid 2 cycles after acceptance. pixel_x and pixel_y are aligned with pixel_data.
- frame_done asserts in the same cycle as pixel_we for (239,159).

Mid-stream reset
- Reset flushes the pipeline. Pixels in flight are lost and no partial writes occur.

Decomposition:
- Package gba_video_pkg:
  - H_ACTIVE and V_ACTIVE localparams.
  - typedef rgb6_t, a struct of r, g, b (6 bits each).
  - typedef bgr555_t.
  - enum cap_state_t {IDLE, LINE, WAIT_LINE}.
- Sub-module gba_color_xform: the stage-1 conversion (mode 0/1), a pure combinational function registered by the parent. This allows its arithmetic to be exhaustively checked standalone.

Test Plan:
- Clean frame: frame_start, then 160 lines of 240 valid pixels separated by line_start, with ppu_pixel={y[4:0],x[4:0],x[4:0]}. Expect 38400 pixel_we. Each write is at the correct (x,y), 2 cycles after its input. Expect one frame_done at (239,159) and sync_err=0.
- Colour modes: pixel R=31, G=0, B=0. Mode 0 gives 0x3F000. Mode 1 gives R=50, G=3, B=3, i.e. pixel_data={6'd50,6'd3,6'd3}. White 0x7FFF in mode 1 gives 62,62,62.
- Short line: line_start after 100 pixels on line 5. Expect sync_err=1 and the next pixel written at (0,6).
- Resync: frame_start during line 80. Expect the next pixel at (0,0) and sync_err=1. The following clean frame_start from IDLE clears sync_err.
- Dropped pixels: valid pixels in IDLE and in WAIT_LINE produce no pixel_we and leave x and y unchanged.
- Async reset between two accepted pixels: outputs go to 0 immediately, no pixel_we follows, and the FSM is in IDLE.

Source files
------------

// File: rtl/gba_video_pkg.sv
// Shared types and raster constants for the GBA video capture path.
package gba_video_pkg;

    localparam int H_ACTIVE = 240;
    localparam int V_ACTIVE = 160;
    localparam int PIPE_LAT = 2;

    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } bgr555_t;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb6_t;

    typedef enum logic [1:0] {IDLE, LINE, WAIT_LINE} cap_state_t;

endpackage

// File: rtl/gba_color_xform.sv
// BGR555 -> RGB6 conversion: plain bit expansion or LCD colour-correction matrix.
module gba_color_xform
    import gba_video_pkg::*;
(
    input  bgr555_t pix_i,
    input  logic    mode_i,
    output rgb6_t   rgb_o
);

    logic [9:0] r10, g10, b10;
    logic [9:0] sum_r, sum_g, sum_b;

    assign r10 = {5'd0, pix_i.r};
    assign g10 = {5'd0, pix_i.g};
    assign b10 = {5'd0, pix_i.b};

    // Row weights sum to 32, so the largest result is 992>>4 = 62: no saturation.
    assign sum_r = 10'd26 * r10 + 10'd4  * g10 + 10'd2  * b10;
    assign sum_g = 10'd2  * r10 + 10'd28 * g10 + 10'd2  * b10;
    assign sum_b = 10'd2  * r10 + 10'd4  * g10 + 10'd26 * b10;

    always_comb begin
        rgb_o = '0;
        if (mode_i) begin
            rgb_o.r = sum_r[9:4];
            rgb_o.g = sum_g[9:4];
            rgb_o.b = sum_b[9:4];
        end else begin
            rgb_o.r = {pix_i.r, pix_i.r[4]};
            rgb_o.g = {pix_i.g, pix_i.g[4]};
            rgb_o.b = {pix_i.b, pix_i.b[4]};
        end
    end

endmodule

// File: rtl/gba_pixel_capture.sv
// Tracks the PPU raster position and emits a 2-cycle-latency (x, y, RGB6, we) frame-buffer write stream.
module gba_pixel_capture
    import gba_video_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ppu_frame_start,
    input  logic        ppu_line_start,
    input  logic [14:0] ppu_pixel,
    input  logic        ppu_pixel_valid,
    input  logic        color_correct,
    output logic [17:0] pixel_data,
    output logic [7:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic        pixel_we,
    output logic        frame_done,
    output logic        sync_err
);

    localparam logic [7:0] X_LAST = 8'(H_ACTIVE - 1);
    localparam logic [7:0] Y_LAST = 8'(V_ACTIVE - 1);

    cap_state_t state_q, state_d, st;
    logic [7:0] x_q, x_d, y_q, y_d, xe, ye;
    logic       serr_q, serr_d;
    logic       acc, acc_last;

    bgr555_t    s0_pix_q;
    logic [7:0] s0_x_q, s0_y_q;
    logic       s0_mode_q, s0_fd_q;
    logic [1:0] vld_pipe_q;

    rgb6_t      rgb, data_q;
    logic [7:0] px_q, py_q;
    logic       fd_q;

    // Strobes resolve first; a pixel in the same cycle lands at the post-strobe position.
    always_comb begin
        st       = state_q;
        xe       = x_q;
        ye       = y_q;
        serr_d   = serr_q;
        acc      = 1'b0;
        acc_last = 1'b0;
        if (ppu_frame_start) begin
            serr_d = (state_q != IDLE);
            st     = LINE;
            xe     = 8'd0;
            ye     = 8'd0;
        end else if (ppu_line_start) begin
            case (state_q)
                WAIT_LINE: begin
                    st = LINE;
                    xe = 8'd0;
                    ye = y_q + 8'd1;
                end
                LINE: begin
                    serr_d = 1'b1;
                    if (y_q == Y_LAST) begin
                        st = IDLE;
                    end else begin
                        xe = 8'd0;
                        ye = y_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
        state_d = st;
        x_d     = xe;
        y_d     = ye;
        if (st == LINE && ppu_pixel_valid) begin
            acc = 1'b1;
            if (xe == X_LAST) begin
                x_d      = 8'd0;
                state_d  = (ye == Y_LAST) ? IDLE : WAIT_LINE;
                acc_last = (ye == Y_LAST);
            end else begin
                x_d = xe + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            serr_q  <= serr_d;
        end
    end

    gba_color_xform u_xform (
        .pix_i  (s0_pix_q),
        .mode_i (s0_mode_q),
        .rgb_o  (rgb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_pix_q   <= '0;
            s0_x_q     <= '0;
            s0_y_q     <= '0;
            s0_mode_q  <= 1'b0;
            s0_fd_q    <= 1'b0;
            vld_pipe_q <= '0;
            data_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], acc};
            s0_fd_q    <= acc_last;
            fd_q       <= s0_fd_q;
            if (acc) begin
                s0_pix_q  <= ppu_pixel;
                s0_x_q    <= xe;
                s0_y_q    <= ye;
                s0_mode_q <= color_correct;
            end
            if (vld_pipe_q[0]) begin
                data_q <= rgb;
                px_q   <= s0_x_q;
                py_q   <= s0_y_q;
            end
        end
    end

    assign pixel_data = data_q;
    assign pixel_x    = px_q;
    assign pixel_y    = py_q;
    assign pixel_we   = vld_pipe_q[1];
    assign frame_done = fd_q;
    assign sync_err   = serr_q;

endmodule

// File: tb/tb_gba_pixel_capture.sv
// Directed bench for gba_pixel_capture: expected writes queued at drive time, checked by a negedge monitor.
module tb_gba_pixel_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        ppu_frame_start, ppu_line_start, ppu_pixel_valid, color_correct;
    logic [14:0] ppu_pixel;
    logic [17:0] pixel_data;
    logic [7:0]  pixel_x, pixel_y;
    logic        pixel_we, frame_done, sync_err;

    gba_pixel_capture dut (
        .clk             (clk),
        .reset           (reset),
        .ppu_frame_start (ppu_frame_start),
        .ppu_line_start  (ppu_line_start),
        .ppu_pixel       (ppu_pixel),
        .ppu_pixel_valid (ppu_pixel_valid),
        .color_correct   (color_correct),
        .pixel_data      (pixel_data),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .pixel_we        (pixel_we),
        .frame_done      (frame_done),
        .sync_err        (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [17:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   fd_cnt = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [17:0] exp0(input logic [14:0] p);
        return {p[4:0], p[4], p[9:5], p[9], p[14:10], p[14]};
    endfunction

    function automatic logic [14:0] gpix(input int x, input int y);
        logic [7:0] xv, yv;
        xv = 8'(x);
        yv = 8'(y);
        return {yv[4:0], xv[4:0], xv[4:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic fs, input logic ls, input logic v, input logic [14:0] d,
                      input logic m, input logic e, input int ex, input int ey, input logic [17:0] ed);
        ppu_frame_start = fs;
        ppu_line_start  = ls;
        ppu_pixel_valid = v;
        ppu_pixel       = d;
        color_correct   = m;
        if (e) q.push_back('{8'(ex), 8'(ey), ed, cyc + 2});
        tick();
        ppu_frame_start = 1'b0;
        ppu_line_start  = 1'b0;
        ppu_pixel_valid = 1'b0;
    endtask

    task automatic line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) px(0, 0, 1, gpix(x, y), 0, 1, x, y, exp0(gpix(x, y)));
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (pixel_we) begin
                if (q.size() == 0) begin
                    chk("unexp_we", pixel_we, 0);
                end else begin
                    me = q.pop_front();
                    chk("wr_xy", {pixel_x, pixel_y}, {me.x, me.y});
                    chk("wr_data", pixel_data, me.d);
                    chk("wr_lat", cyc, me.c);
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_xy", {pixel_we, pixel_x, pixel_y}, {1'b1, 8'd239, 8'd159});
            end
        end
    end

    initial begin
        reset = 1'b1;
        ppu_frame_start = 0; ppu_line_start = 0; ppu_pixel_valid = 0;
        ppu_pixel = '0; color_correct = 0;
        tick(); tick();
        chk("rst_we", pixel_we, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_serr", sync_err, 0);
        chk("rst_data", pixel_data, 0);
        chk("rst_xy", {pixel_x, pixel_y}, 0);
        reset = 1'b0;
        tick();

        // pixels with no frame_start are dropped
        repeat (4) px(0, 0, 1, 15'h1234, 0, 0, 0, 0, 0);

        // clean frame, with stray valid pixels while waiting for each line_start
        px(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int y = 0; y < 160; y++) begin
            line(y, 0, 239);
            if (y < 159) begin
                px(0, 0, 1, 15'h7FFF, 0, 0, 0, 0, 0);
                px(0, 0, 1, 15'h7FFF, 0, 0, 0, 0, 0);
                px(0, 1, 0, 0, 0, 0, 0, 0, 0);
            end
        end
        repeat (4) tick();
        chk("f1_done", fd_cnt, 1);
        chk("f1_pend", q.size(), 0);
        chk("f1_serr", sync_err, 0);

        // colour modes, first pixel in the frame_start cycle
        px(1, 0, 1, 15'h001F, 0, 1, 0, 0, 18'h3F000);
        px(0, 0, 1, 15'h001F, 1, 1, 1, 0, {6'd50, 6'd3, 6'd3});
        px(0, 0, 1, 15'h7FFF, 1, 1, 2, 0, {6'd62, 6'd62, 6'd62});
        px(0, 0, 1, 15'h03E0, 1, 1, 3, 0, {6'd7, 6'd54, 6'd7});
        px(0, 0, 1, 15'h7FFF, 0, 1, 4, 0, 18'h3FFFF);
        px(0, 0, 1, {5'd3, 5'd2, 5'd1}, 1, 1, 5, 0, {6'd2, 6'd4, 6'd5});
        line(0, 6, 239);
        px(0, 1, 1, gpix(0, 1), 0, 1, 0, 1, exp0(gpix(0, 1)));
        line(1, 1, 239);
        for (int y = 2; y <= 5; y++) begin
            px(0, 1, 0, 0, 0, 0, 0, 0, 0);
            if (y < 5) line(y, 0, 239);
            else line(5, 0, 99);
        end
        chk("pre_short_serr", sync_err, 0);
        px(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("short_serr", sync_err, 1);
        px(0, 0, 1, gpix(0, 6), 0, 1, 0, 6, exp0(gpix(0, 6)));
        for (int y = 7; y <= 80; y++) px(0, 1, 1, gpix(0, y), 0, 1, 0, y, exp0(gpix(0, y)));
        line(80, 1, 10);

        // resync mid-frame, pixel in the same cycle lands at (0,0)
        px(1, 0, 1, gpix(0, 0), 0, 1, 0, 0, exp0(gpix(0, 0)));
        chk("resync_serr", sync_err, 1);
        for (int y = 1; y <= 159; y++) px(0, 1, 1, gpix(0, y), 0, 1, 0, y, exp0(gpix(0, y)));
        px(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) px(0, 0, 1, 15'h2AAA, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("f2_done", fd_cnt, 1);
        chk("f2_pend", q.size(), 0);
        chk("f2_serr_sticky", sync_err, 1);
        px(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("clean_clr", sync_err, 0);

        // async reset between two accepted pixels
        mon_en = 1'b0;
        px(0, 0, 1, 15'h1234, 0, 0, 0, 0, 0);
        px(0, 0, 1, 15'h4321, 0, 0, 0, 0, 0);
        chk("pre_rst_we", pixel_we, 1);
        chk("pre_rst_data", pixel_data, {6'd41, 6'd35, 6'd8});
        #2 reset = 1'b1;
        #1;
        chk("arst_we", pixel_we, 0);
        chk("arst_data", pixel_data, 0);
        chk("arst_xy", {pixel_x, pixel_y}, 0);
        chk("arst_fd", frame_done, 0);
        tick();
        chk("arst_hold_we", pixel_we, 0);
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (4) px(0, 0, 1, 15'h0F0F, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("post_rst_we", pixel_we, 0);
        chk("post_rst_serr", sync_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
